wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Write-back arbiter that merges results from the single-cycle ALU path and the variable-latency load path onto the register file's single write port (`rf_wen`/`rf_waddr`/`rf_wdata`). ALU results have strict priority and are never back-pressured. Load results pass through a small FIFO and drain in idle ALU slots. The block also gives the issue logic a pending-write scoreboard and, optionally, operand forwarding for registers whose value has not yet reached the register file.

## Interface
- `N`, 32, number of architectural registers (address width `AW = $clog2(N)`)
- `W`, 32, data width
- `DEPTH`, 4, load FIFO depth; power of two, ≥2
- `NQ`, 3, number of scoreboard query ports (rs1, rs2, rd)

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `alu_valid`  in  1  ALU result present this cycle
- `alu_rd`  in  AW  ALU destination
- `alu_data`  in  W  ALU result
- `ld_valid`  in  1  load result offered
- `ld_ready`  out  1  load result accepted when `ld_valid && ld_ready`
- `ld_rd`  in  AW  load destination
- `ld_data`  in  W  load data
- `alu_stall`  out  1  FIFO full; issue must insert an ALU bubble next cycle
- `rf_wen`  out  1  register-file write enable
- `rf_waddr`  out  AW  register-file write address
- `rf_wdata`  out  W  register-file write data
- `q_addr`  in  NQ×AW  query addresses
- `q_pending`  out  NQ  write to `q_addr[i]` still in flight
- `q_fwd_hit`  out  NQ  forwarded value valid (WB_FWD_EN only)
- `q_fwd_data`  out  NQ×W  forwarded value (WB_FWD_EN only)
- `fifo_count`  out  $clog2(DEPTH+1)  current FIFO occupancy

## Operation
- **Output register** (`rf_wen`/`rf_waddr`/`rf_wdata`): loaded every cycle by priority:
  1. `alu_valid && alu_rd != 0`: ALU entry.
  2. Else, FIFO non-empty: pop head.
  3. Else: `rf_wen = 0`; address and data hold.
- **x0 handling:** ALU writes to x0 are dropped. Load handshakes with `ld_rd == 0` complete normally but are not enqueued.
- **Load acceptance:** `ld_ready = (fifo_count < DEPTH) && !reset`. This is registered-count based, so a same-cycle pop does not free a slot early. A push and a pop in the same cycle leave the count unchanged.
- **Stall request:** `alu_stall = (fifo_count == DEPTH)`. Issue logic must then hold ALU issue for at least one cycle so the FIFO can drain. Loads may starve indefinitely otherwise; the bench flags this as an upstream contract violation.
- **Pending check:** `q_pending[i] = (q_addr[i] != 0) && (match in any valid FIFO entry || (rf_wen && rf_waddr == q_addr[i]))`. This is purely combinational.
- **Issue contract:** no instruction issues while its rd is pending (no WAW), so at most one in-flight entry matches any address. The bench asserts this.

## Timing
- ALU result to `rf_wen`: 1 cycle.
- Load handshake to `rf_wen`: minimum 2 cycles (enqueue at edge k, pop into output register at edge k+1); longer while the ALU occupies slots.
- The register file commits at the edge after `rf_wen`. Until then the entry is still reported pending.
- **Reset (asynchronous):** FIFO empty with pointers at 0; `rf_wen = 0`, `rf_waddr = 0`, `rf_wdata = 0`; `fifo_count = 0`; `ld_ready = 0` while reset is asserted and 1 in the first cycle after release. Entries in flight at reset are discarded.
- **Wrap-around:** pointers are `$clog2(DEPTH)+1` bits; full/empty are taken from the MSB compare.

## Configuration
- `WB_FWD_EN` defined: `q_fwd_hit[i]` is set on the unique pending match, and `q_fwd_data[i]` carries that entry's data (output register or FIFO slot).
- `WB_FWD_EN` undefined: `q_fwd_hit` and `q_fwd_data` are tied to 0, and the FIFO data-match mux is not built. Issue logic stalls on `q_pending` instead.

## Structure
- **Package `wb_pkg`:** `wb_entry_t` struct {rd[AW], data[W]}, default `DEPTH`, and a helper function for `q_pending` address matching.
- **Sub-module `wb_fifo`:** parameterised on `DEPTH` and `wb_entry_t`; exposes push/pop, count, and flat entry/valid vectors for the scoreboard. `wb_arbiter` contains the output register, priority select, and query logic.

## Test plan
- **Reset:** assert `reset` mid-traffic → all outputs 0 immediately; `ld_ready = 1` one cycle after release.
- **ALU only:** `alu_valid`, rd=5, data=0xDEAD_BEEF → `rf_wen = 1`, `waddr = 5`, `wdata = 0xDEADBEEF` next cycle. rd=0 → `rf_wen = 0`.
- **Load only:** one load, rd=7, data=0x1234 → written 2 cycles after the handshake; `q_pending` for 7 high from handshake+1 until the write cycle inclusive.
- **Contention:** ALU active every cycle while 4 loads arrive → `fifo_count = 4`, `ld_ready = 0`, `alu_stall = 1`. The ALU bubble pops exactly one load, in FIFO order.
- **Forwarding (WB_FWD_EN):** load rd=9, data=0xAA queued behind ALU traffic, query 9 → `q_fwd_hit = 1`, `q_fwd_data = 0xAA`. Without the macro: hit=0, pending=1.
- **Simultaneous:** push and pop in the same cycle at count=2 → count stays 2; no data loss over 1000 random-cycle iterations, checked against a reference model.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and helpers for the write-back arbiter.
// wb_entry_t carries one pending register write {rd, data}.
// wb_addr_hit() is the pending-write address match used by the query ports.
package wb_pkg;

   localparam int unsigned WB_N     = 32;
   localparam int unsigned WB_W     = 32;
   localparam int unsigned WB_AW    = $clog2(WB_N);
   localparam int unsigned WB_DEPTH = 4;

   typedef struct packed {
      logic [WB_AW-1:0] rd;
      logic [WB_W-1:0]  data;
   } wb_entry_t;

   // x0 is never pending, so address 0 never matches.
   function automatic logic wb_addr_hit(input logic [WB_AW-1:0] q,
                                        input logic [WB_AW-1:0] e,
                                        input logic             v);
      return v && (q != '0) && (q == e);
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Load-result FIFO for the write-back arbiter.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   push, push_data      enqueue (ignored when full)
//   pop, head            dequeue (ignored when empty), head entry
//   count, full, empty   occupancy status
//   entries, valid       every slot and its occupancy, for scoreboard matching
module wb_fifo
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH = WB_DEPTH,
   parameter type         T     = wb_entry_t
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  T                           push_data,
   input  logic                       pop,
   output T                           head,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty,
   output T                           entries [DEPTH],
   output logic [DEPTH-1:0]           valid
);

   localparam int unsigned IW = $clog2(DEPTH);
   localparam int unsigned PW = IW + 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   T              mem [DEPTH];

   // Extra pointer MSB distinguishes full from empty when the indices coincide.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
   assign count = CW'(wr_ptr - rd_ptr);
   assign head  = mem[rd_ptr[IW-1:0]];
   assign entries = mem;

   // Pointer state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)  wr_ptr <= wr_ptr + PW'(1);
         if (pop  && !empty) rd_ptr <= rd_ptr + PW'(1);
      end
   end

   // Storage; contents are qualified by valid, so no reset needed
   always_ff @(posedge clk) begin
      if (push && !full) mem[wr_ptr[IW-1:0]] <= push_data;
   end

   // A slot is live when its distance from the read pointer is below the count
   for (genvar i = 0; i < DEPTH; i++) begin : g_valid
      logic [IW-1:0] offset;
      assign offset   = IW'(i) - rd_ptr[IW-1:0];
      assign valid[i] = (CW'(offset) < count);
   end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges single-cycle ALU results and queued load results
// onto the single register-file write port, and reports in-flight writes.
// ALU results have strict priority; loads drain through wb_fifo in idle slots.
// Ports:
//   clk, reset                         clock, asynchronous active-high reset
//   alu_valid/alu_rd/alu_data          ALU result (never back-pressured)
//   ld_valid/ld_ready/ld_rd/ld_data    load result handshake
//   alu_stall                          FIFO full, issue must bubble the ALU
//   rf_wen/rf_waddr/rf_wdata           registered register-file write port
//   q_addr/q_pending                   pending-write queries
//   q_fwd_hit/q_fwd_data               forwarded value of a pending write
//   fifo_count                         load FIFO occupancy
// Build option: define WB_FWD_EN to enable operand forwarding; otherwise
// q_fwd_hit and q_fwd_data are tied to zero.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter  int unsigned N     = WB_N,
   parameter  int unsigned W     = WB_W,
   parameter  int unsigned DEPTH = WB_DEPTH,
   parameter  int unsigned NQ    = 3,
   localparam int unsigned AW    = $clog2(N),
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                alu_valid,
   input  logic [AW-1:0]       alu_rd,
   input  logic [W-1:0]        alu_data,
   input  logic                ld_valid,
   output logic                ld_ready,
   input  logic [AW-1:0]       ld_rd,
   input  logic [W-1:0]        ld_data,
   output logic                alu_stall,
   output logic                rf_wen,
   output logic [AW-1:0]       rf_waddr,
   output logic [W-1:0]        rf_wdata,
   input  logic [NQ-1:0][AW-1:0] q_addr,
   output logic [NQ-1:0]       q_pending,
   output logic [NQ-1:0]       q_fwd_hit,
   output logic [NQ-1:0][W-1:0] q_fwd_data,
   output logic [CW-1:0]       fifo_count
);

   wb_entry_t        fifo_push_data;
   wb_entry_t        fifo_head;
   wb_entry_t        fifo_entries [DEPTH];
   logic [DEPTH-1:0] fifo_valid;
   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_push;
   logic             fifo_pop;
   logic             alu_take;

   // Handshake and priority decode
   assign ld_ready       = (fifo_count < CW'(DEPTH)) && !reset;
   assign alu_stall      = fifo_full;
   assign alu_take       = alu_valid && (alu_rd != '0);
   assign fifo_push      = ld_valid && ld_ready && (ld_rd != '0);
   assign fifo_pop       = !alu_take && !fifo_empty;
   assign fifo_push_data = wb_entry_t'{rd: WB_AW'(ld_rd), data: WB_W'(ld_data)};

   wb_fifo #(
      .DEPTH (DEPTH),
      .T     (wb_entry_t)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (fifo_push_data),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .entries   (fifo_entries),
      .valid     (fifo_valid)
   );

   // Output register: ALU first, then FIFO head; address/data hold when idle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rf_wen   <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         rf_wen <= alu_take || !fifo_empty;
         if (alu_take) begin
            rf_waddr <= alu_rd;
            rf_wdata <= alu_data;
         end else if (!fifo_empty) begin
            rf_waddr <= AW'(fifo_head.rd);
            rf_wdata <= W'(fifo_head.data);
         end
      end
   end

   // Pending query: any live FIFO slot or the write currently on the port
   always_comb begin
      q_pending = '0;
      for (int i = 0; i < NQ; i++) begin
         logic hit;
         hit = wb_addr_hit(WB_AW'(q_addr[i]), WB_AW'(rf_waddr), rf_wen);
         for (int j = 0; j < DEPTH; j++) begin
            hit = hit | wb_addr_hit(WB_AW'(q_addr[i]), fifo_entries[j].rd, fifo_valid[j]);
         end
         q_pending[i] = hit;
      end
   end

`ifdef WB_FWD_EN
   // At most one in-flight write matches an address, so an OR-mux suffices
   always_comb begin
      q_fwd_hit  = q_pending;
      q_fwd_data = '0;
      for (int i = 0; i < NQ; i++) begin
         if (wb_addr_hit(WB_AW'(q_addr[i]), WB_AW'(rf_waddr), rf_wen))
            q_fwd_data[i] = q_fwd_data[i] | rf_wdata;
         for (int j = 0; j < DEPTH; j++) begin
            if (wb_addr_hit(WB_AW'(q_addr[i]), fifo_entries[j].rd, fifo_valid[j]))
               q_fwd_data[i] = q_fwd_data[i] | W'(fifo_entries[j].data);
         end
      end
   end
`else
   assign q_fwd_hit  = '0;
   assign q_fwd_data = '0;

   // Slot data is only consumed by forwarding
   logic unused_fwd;
   always_comb begin
      unused_fwd = 1'b0;
      for (int j = 0; j < DEPTH; j++) unused_fwd = unused_fwd ^ (^fifo_entries[j].data);
   end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: a reference model pushes the expected
// write-port state each cycle and a monitor pops and compares it.
module tb_wb_arbiter;

   localparam int unsigned DEPTH       = 4;
   localparam int          STARVE_LIMIT = 32;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   typedef struct {
      logic        wen;
      logic [4:0]  addr;
      logic [31:0] data;
      int unsigned count;
   } exp_t;

   logic            clk;
   logic            reset;
   logic            alu_valid;
   logic [4:0]      alu_rd;
   logic [31:0]     alu_data;
   logic            ld_valid;
   logic            ld_ready;
   logic [4:0]      ld_rd;
   logic [31:0]     ld_data;
   logic            alu_stall;
   logic            rf_wen;
   logic [4:0]      rf_waddr;
   logic [31:0]     rf_wdata;
   logic [2:0][4:0] q_addr;
   logic [2:0]      q_pending;
   logic [2:0]      q_fwd_hit;
   logic [2:0][31:0] q_fwd_data;
   logic [2:0]      fifo_count;

   int   checks;
   int   failures;

   // reference model state
   ent_t        mq [$];
   exp_t        exp_q [$];
   logic        m_wen;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   int          starve;

   wb_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .alu_valid  (alu_valid),
      .alu_rd     (alu_rd),
      .alu_data   (alu_data),
      .ld_valid   (ld_valid),
      .ld_ready   (ld_ready),
      .ld_rd      (ld_rd),
      .ld_data    (ld_data),
      .alu_stall  (alu_stall),
      .rf_wen     (rf_wen),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata),
      .q_addr     (q_addr),
      .q_pending  (q_pending),
      .q_fwd_hit  (q_fwd_hit),
      .q_fwd_data (q_fwd_data),
      .fifo_count (fifo_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic bit in_flight(input logic [4:0] r);
      if (r == 5'd0) return 1'b0;
      if (m_wen && m_addr == r) return 1'b1;
      foreach (mq[i]) if (mq[i].rd == r) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_fwd(input logic [4:0] r);
      if (r == 5'd0) return 32'd0;
      if (m_wen && m_addr == r) return m_data;
      foreach (mq[i]) if (mq[i].rd == r) return mq[i].data;
      return 32'd0;
   endfunction

   // Reference model: evaluates the cycle at each edge and queues the expected outputs
   initial begin
      ent_t e;
      bit   mtake;
      bit   mhs;
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            mq.delete();
            exp_q.delete();
            m_wen  = 1'b0;
            m_addr = 5'd0;
            m_data = 32'd0;
            starve = 0;
            exp_q.push_back('{wen: 1'b0, addr: 5'd0, data: 32'd0, count: 0});
         end else begin
            mtake = alu_valid && (alu_rd != 5'd0);
            mhs   = ld_valid && (mq.size() < DEPTH);
            if (mtake) begin
               checks++;
               if (in_flight(alu_rd)) begin
                  failures++;
                  $display("FAIL waw_alu: rd=%0d issued while pending, required not pending", alu_rd);
               end
            end
            if (mhs && ld_rd != 5'd0) begin
               checks++;
               if (in_flight(ld_rd) || (mtake && alu_rd == ld_rd)) begin
                  failures++;
                  $display("FAIL waw_load: rd=%0d accepted while pending, required not pending", ld_rd);
               end
            end
            if (mtake) begin
               m_wen  = 1'b1;
               m_addr = alu_rd;
               m_data = alu_data;
               if (mq.size() > 0) starve++;
            end else if (mq.size() > 0) begin
               e      = mq.pop_front();
               m_wen  = 1'b1;
               m_addr = e.rd;
               m_data = e.data;
               starve = 0;
            end else begin
               m_wen = 1'b0;
            end
            if (mhs && ld_rd != 5'd0) mq.push_back('{rd: ld_rd, data: ld_data});
            if (mq.size() > 0) begin
               checks++;
               if (starve > STARVE_LIMIT) begin
                  failures++;
                  $display("FAIL load_starvation: %0d ALU cycles without drain, required <= %0d", starve, STARVE_LIMIT);
               end
            end
            exp_q.push_back('{wen: m_wen, addr: m_addr, data: m_data, count: mq.size()});
         end
      end
   end

   // Monitor: pops one expectation per cycle and compares the registered outputs
   initial begin
      exp_t ex;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            checks++;
            if (rf_wen !== ex.wen || rf_waddr !== ex.addr || rf_wdata !== ex.data) begin
               failures++;
               $display("FAIL sb_rf_port: got wen=%0b addr=%0d data=%h, expected wen=%0b addr=%0d data=%h",
                        rf_wen, rf_waddr, rf_wdata, ex.wen, ex.addr, ex.data);
            end
            checks++;
            if (fifo_count !== 3'(ex.count)) begin
               failures++;
               $display("FAIL sb_fifo_count: got %0d expected %0d", fifo_count, ex.count);
            end
            checks++;
            if (ld_ready !== (!reset && ex.count < DEPTH)) begin
               failures++;
               $display("FAIL sb_ld_ready: got %0b expected %0b", ld_ready, (!reset && ex.count < DEPTH));
            end
            checks++;
            if (alu_stall !== (ex.count == DEPTH)) begin
               failures++;
               $display("FAIL sb_alu_stall: got %0b expected %0b", alu_stall, (ex.count == DEPTH));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog");
   end

   task automatic idle();
      alu_valid = 1'b0;
      alu_rd    = 5'd0;
      alu_data  = 32'd0;
      ld_valid  = 1'b0;
      ld_rd     = 5'd0;
      ld_data   = 32'd0;
   endtask

   // Inputs change at the falling edge; outputs are sampled at the next falling edge
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [4:0] pick_rd(input logic [4:0] avoid);
      logic [4:0] r;
      if ($urandom_range(0, 9) == 0) return 5'd0;
      do r = 5'($urandom_range(1, 31)); while (in_flight(r) || r == avoid);
      return r;
   endfunction

   task automatic test_reset();
      reset  = 1'b1;
      q_addr = '0;
      idle();
      repeat (2) tick();
      checks++;
      if (rf_wen !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || fifo_count !== 3'd0) begin
         failures++;
         $display("FAIL reset_outputs: got wen=%0b addr=%0d data=%h count=%0d, expected all 0",
                  rf_wen, rf_waddr, rf_wdata, fifo_count);
      end
      checks++;
      if (ld_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_ld_ready: got %0b expected 0", ld_ready);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if (ld_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_release_ld_ready: got %0b expected 1", ld_ready);
      end
      @(negedge clk);
   endtask

   task automatic test_alu_only();
      alu_valid = 1'b1;
      alu_rd    = 5'd5;
      alu_data  = 32'hDEAD_BEEF;
      tick();
      checks++;
      if (rf_wen !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEAD_BEEF) begin
         failures++;
         $display("FAIL alu_write: got wen=%0b addr=%0d data=%h, expected 1/5/deadbeef", rf_wen, rf_waddr, rf_wdata);
      end
      alu_rd   = 5'd0;
      alu_data = 32'h1111_1111;
      tick();
      checks++;
      if (rf_wen !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEAD_BEEF) begin
         failures++;
         $display("FAIL alu_x0_dropped: got wen=%0b addr=%0d data=%h, expected 0/5/deadbeef", rf_wen, rf_waddr, rf_wdata);
      end
      idle();
      tick();
   endtask

   task automatic test_load_only();
      q_addr[0] = 5'd7;
      ld_valid  = 1'b1;
      ld_rd     = 5'd7;
      ld_data   = 32'h1234;
      #1;
      checks++;
      if (q_pending[0] !== 1'b0) begin
         failures++;
         $display("FAIL load_pending_before: got %0b expected 0", q_pending[0]);
      end
      tick();
      idle();
      checks++;
      if (q_pending[0] !== 1'b1 || rf_wen !== 1'b0 || fifo_count !== 3'd1) begin
         failures++;
         $display("FAIL load_queued: got pend=%0b wen=%0b count=%0d, expected 1/0/1", q_pending[0], rf_wen, fifo_count);
      end
      tick();
      checks++;
      if (q_pending[0] !== 1'b1 || rf_wen !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h1234) begin
         failures++;
         $display("FAIL load_write: got pend=%0b wen=%0b addr=%0d data=%h, expected 1/1/7/1234",
                  q_pending[0], rf_wen, rf_waddr, rf_wdata);
      end
      tick();
      checks++;
      if (q_pending[0] !== 1'b0 || rf_wen !== 1'b0) begin
         failures++;
         $display("FAIL load_committed: got pend=%0b wen=%0b, expected 0/0", q_pending[0], rf_wen);
      end
      q_addr = '0;
   endtask

   task automatic test_contention();
      for (int c = 0; c < 4; c++) begin
         alu_valid = 1'b1;
         alu_rd    = 5'(16 + c);
         alu_data  = 32'hA000 + 32'(c);
         ld_valid  = 1'b1;
         ld_rd     = 5'(10 + c);
         ld_data   = 32'h100 + 32'(c);
         tick();
      end
      checks++;
      if (fifo_count !== 3'd4 || ld_ready !== 1'b0 || alu_stall !== 1'b1 || rf_waddr !== 5'd19) begin
         failures++;
         $display("FAIL contention_full: got count=%0d ready=%0b stall=%0b addr=%0d, expected 4/0/1/19",
                  fifo_count, ld_ready, alu_stall, rf_waddr);
      end
      alu_rd   = 5'd20;
      alu_data = 32'hA004;
      ld_rd    = 5'd14;
      ld_data  = 32'h104;
      tick();
      checks++;
      if (fifo_count !== 3'd4 || rf_waddr !== 5'd20) begin
         failures++;
         $display("FAIL contention_no_push_when_full: got count=%0d addr=%0d, expected 4/20", fifo_count, rf_waddr);
      end
      alu_valid = 1'b0;
      tick();
      checks++;
      if (rf_wen !== 1'b1 || rf_waddr !== 5'd10 || rf_wdata !== 32'h100 || fifo_count !== 3'd3) begin
         failures++;
         $display("FAIL contention_bubble_pop: got wen=%0b addr=%0d data=%h count=%0d, expected 1/10/100/3",
                  rf_wen, rf_waddr, rf_wdata, fifo_count);
      end
      alu_valid = 1'b1;
      alu_rd    = 5'd21;
      alu_data  = 32'hA005;
      tick();
      checks++;
      if (fifo_count !== 3'd4 || rf_waddr !== 5'd21) begin
         failures++;
         $display("FAIL contention_refill: got count=%0d addr=%0d, expected 4/21", fifo_count, rf_waddr);
      end
      idle();
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++;
         if (rf_wen !== 1'b1 || rf_waddr !== 5'(10 + k) || rf_wdata !== 32'h100 + 32'(k)) begin
            failures++;
            $display("FAIL contention_drain_order: got wen=%0b addr=%0d data=%h, expected 1/%0d/%h",
                     rf_wen, rf_waddr, rf_wdata, 10 + k, 32'h100 + 32'(k));
         end
      end
      tick();
   endtask

   task automatic test_forwarding();
      q_addr[0] = 5'd22;
      q_addr[1] = 5'd9;
      q_addr[2] = 5'd0;
      alu_valid = 1'b1;
      alu_rd    = 5'd22;
      alu_data  = 32'h2222_0000;
      ld_valid  = 1'b1;
      ld_rd     = 5'd9;
      ld_data   = 32'hAA;
      tick();
      checks++;
      if (q_pending[0] !== 1'b1 || q_pending[2] !== 1'b0) begin
         failures++;
         $display("FAIL fwd_pending_outreg: got pend0=%0b pend2=%0b, expected 1/0", q_pending[0], q_pending[2]);
      end
`ifdef WB_FWD_EN
      checks++;
      if (q_fwd_hit[0] !== 1'b1 || q_fwd_data[0] !== 32'h2222_0000) begin
         failures++;
         $display("FAIL fwd_outreg: got hit=%0b data=%h, expected 1/22220000", q_fwd_hit[0], q_fwd_data[0]);
      end
`endif
      ld_valid = 1'b0;
      alu_rd   = 5'd23;
      alu_data = 32'h2323_0000;
      tick();
      checks++;
      if (q_pending[1] !== 1'b1 || rf_waddr !== 5'd23 || fifo_count !== 3'd1) begin
         failures++;
         $display("FAIL fwd_queued: got pend=%0b addr=%0d count=%0d, expected 1/23/1", q_pending[1], rf_waddr, fifo_count);
      end
`ifdef WB_FWD_EN
      checks++;
      if (q_fwd_hit[1] !== 1'b1 || q_fwd_data[1] !== 32'hAA) begin
         failures++;
         $display("FAIL fwd_fifo_slot: got hit=%0b data=%h, expected 1/aa", q_fwd_hit[1], q_fwd_data[1]);
      end
`else
      checks++;
      if (q_fwd_hit !== 3'b000 || q_fwd_data[1] !== 32'd0) begin
         failures++;
         $display("FAIL fwd_disabled: got hit=%b data=%h, expected 000/0", q_fwd_hit, q_fwd_data[1]);
      end
`endif
      alu_valid = 1'b0;
      tick();
      checks++;
      if (q_pending[1] !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'hAA) begin
         failures++;
         $display("FAIL fwd_popped: got pend=%0b addr=%0d data=%h, expected 1/9/aa", q_pending[1], rf_waddr, rf_wdata);
      end
      tick();
      checks++;
      if (q_pending[1] !== 1'b0 || q_fwd_hit[1] !== 1'b0) begin
         failures++;
         $display("FAIL fwd_committed: got pend=%0b hit=%0b, expected 0/0", q_pending[1], q_fwd_hit[1]);
      end
      idle();
      q_addr = '0;
   endtask

   task automatic test_simultaneous();
      logic [4:0] qa;
      alu_valid = 1'b1;
      alu_rd    = 5'd24;
      alu_data  = 32'h2424;
      ld_valid  = 1'b1;
      ld_rd     = 5'd12;
      ld_data   = 32'h55;
      tick();
      alu_rd   = 5'd25;
      alu_data = 32'h2525;
      ld_rd    = 5'd13;
      ld_data  = 32'h66;
      tick();
      alu_valid = 1'b0;
      ld_rd     = 5'd14;
      ld_data   = 32'h77;
      tick();
      checks++;
      if (fifo_count !== 3'd2 || rf_waddr !== 5'd12 || rf_wdata !== 32'h55) begin
         failures++;
         $display("FAIL simul_push_pop: got count=%0d addr=%0d data=%h, expected 2/12/55", fifo_count, rf_waddr, rf_wdata);
      end
      idle();
      repeat (3) tick();

      // random traffic, ALU bubbles whenever the arbiter requests a stall
      for (int n = 0; n < 1000; n++) begin
         alu_valid = !alu_stall && ($urandom_range(0, 99) < 70);
         alu_rd    = pick_rd(5'd0);
         alu_data  = $urandom;
         ld_valid  = ($urandom_range(0, 99) < 50);
         ld_rd     = pick_rd(alu_rd);
         ld_data   = $urandom;
         q_addr[0] = 5'($urandom_range(0, 31));
         tick();
         qa = q_addr[0];
         checks++;
         if (q_pending[0] !== in_flight(qa)) begin
            failures++;
            $display("FAIL rand_pending: addr=%0d got %0b expected %0b", qa, q_pending[0], in_flight(qa));
         end
`ifdef WB_FWD_EN
         checks++;
         if (q_fwd_hit[0] !== in_flight(qa) || q_fwd_data[0] !== model_fwd(qa)) begin
            failures++;
            $display("FAIL rand_fwd: addr=%0d got hit=%0b data=%h expected %0b/%h",
                     qa, q_fwd_hit[0], q_fwd_data[0], in_flight(qa), model_fwd(qa));
         end
`endif
      end
      idle();
      q_addr = '0;
      repeat (DEPTH + 2) tick();
      checks++;
      if (fifo_count !== 3'd0 || rf_wen !== 1'b0) begin
         failures++;
         $display("FAIL rand_drained: got count=%0d wen=%0b, expected 0/0", fifo_count, rf_wen);
      end
   endtask

   task automatic test_reset_mid();
      alu_valid = 1'b1;
      alu_rd    = 5'd3;
      alu_data  = 32'h3;
      ld_valid  = 1'b1;
      ld_rd     = 5'd4;
      ld_data   = 32'h4;
      tick();
      alu_rd   = 5'd5;
      alu_data = 32'h5;
      ld_rd    = 5'd6;
      ld_data  = 32'h6;
      tick();
      idle();
      q_addr[0] = 5'd4;
      q_addr[1] = 5'd6;
      q_addr[2] = 5'd5;
      #1;
      checks++;
      if (q_pending !== 3'b111 || fifo_count !== 3'd2) begin
         failures++;
         $display("FAIL mid_pre_reset: got pend=%b count=%0d, expected 111/2", q_pending, fifo_count);
      end
      #1 reset = 1'b1;
      #1;
      checks++;
      if (rf_wen !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || fifo_count !== 3'd0 ||
          ld_ready !== 1'b0 || q_pending !== 3'b000) begin
         failures++;
         $display("FAIL mid_reset_async: got wen=%0b addr=%0d data=%h count=%0d ready=%0b pend=%b, expected all 0",
                  rf_wen, rf_waddr, rf_wdata, fifo_count, ld_ready, q_pending);
      end
      @(negedge clk);
      tick();
      #2 reset = 1'b0;
      #1;
      checks++;
      if (ld_ready !== 1'b1) begin
         failures++;
         $display("FAIL mid_reset_release: got ld_ready=%0b expected 1", ld_ready);
      end
      @(negedge clk);
      tick();
      checks++;
      if (q_pending !== 3'b000 || rf_wen !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset_discard: got pend=%b wen=%0b, expected 000/0", q_pending, rf_wen);
      end
      q_addr = '0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_alu_only();
      test_load_only();
      test_contention();
      test_forwarding();
      test_simultaneous();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
